// File: rtl/twi_pkg.sv
// Shared constants and helpers for the TWI core and its FIFO.
package twi_pkg;

    localparam int TWI_AW = 4;
    localparam int TWI_DW = 8;

    // Occupancy from two wrap-bit pointers: (wr - rd) mod 2**(aw+1).
    function automatic logic [31:0] ptr_diff(input logic [31:0] wr,
                                             input logic [31:0] rd,
                                             input int          aw);
        logic [31:0] mask;
        mask = (32'd1 << (aw + 1)) - 32'd1;
        return (wr - rd) & mask;
    endfunction

endpackage

// File: rtl/twi_fifo_ram.sv
// FIFO storage: 2**AW x DW, one write port, one registered read port.
module twi_fifo_ram
    import twi_pkg::*;
#(
    parameter int AW = TWI_AW,
    parameter int DW = TWI_DW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // The read register only updates on an accepted read, so it holds its last value otherwise.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/twi_fifo.sv
// Synchronous FIFO with registered read data and wrap-bit pointers.
// Define TWI_FIFO_STATUS_EN to build level_o, ovf_o and udf_o; otherwise they read 0.
module twi_fifo
    import twi_pkg::*;
#(
    parameter int AW = TWI_AW,
    parameter int DW = TWI_DW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          wr_i,
    input  logic [DW-1:0] di_i,
    output logic          full_o,
    input  logic          rd_i,
    output logic [DW-1:0] do_o,
    output logic          do_vld_o,
    output logic          empty_o,
    output logic [AW:0]   level_o,
    output logic          ovf_o,
    output logic          udf_o
);

    localparam int LW = AW + 1;

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_vld_q, do_vld_d;
    logic        wr_acc, rd_acc;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A write into a full FIFO is accepted only when a read frees the slot in the same edge.
    assign rd_acc = rd_i && !empty_o && !clr_i;
    assign wr_acc = wr_i && (!full_o || rd_i) && !clr_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_vld_d = rd_acc;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            do_vld_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            do_vld_q <= do_vld_d;
        end
    end

    assign do_vld_o = do_vld_q;

    twi_fifo_ram #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (di_i),
        .re_i    (rd_acc),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (do_o)
    );

`ifdef TWI_FIFO_STATUS_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    // Sticky error flags record rejected strobes until a flush or reset.
    always_comb begin
        ovf_d = ovf_q | (wr_i && !rd_i && full_o);
        udf_d = udf_q | (rd_i && empty_o);
        if (clr_i) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign ovf_o   = ovf_q;
    assign udf_o   = udf_q;
    assign level_o = LW'(ptr_diff(32'(wr_ptr_q), 32'(rd_ptr_q), AW));
`else
    assign ovf_o   = 1'b0;
    assign udf_o   = 1'b0;
    assign level_o = '0;
`endif

endmodule
